// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of NCH prescaled timer channels with compare match, one-shot/periodic mode and sticky flags.
// Define CAPTURE_EN to add per-channel synchronised capture of COUNT on capture_in rising edges.
module mmio_timer_bank #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [NCH-1:0]    capture_in,
  output logic              irq
);

  localparam int CH_W = ADDR_W - 3;

  logic [CH_W-1:0] a_ch;
  logic [2:0]      a_reg;
  logic            status_wr;

  assign a_ch      = addr[ADDR_W-1:3];
  assign a_reg     = addr[2:0];
  assign status_wr = we && (a_ch == CH_W'(NCH)) && (a_reg == 3'd0);

  logic [NCH-1:0]             en_v, per_v, irqen_v, flag_v;
  logic [NCH-1:0][PRE_W-1:0]  pre_v;
  logic [NCH-1:0][CNT_W-1:0]  cmp_v, cnt_v, cap_v;

`ifndef CAPTURE_EN
  logic unused_capture;
  assign unused_capture = ^capture_in;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             en, periodic, irqen, flag;
    logic [PRE_W-1:0] prescale, pc;
    logic [CNT_W-1:0] compare, count, capture;
    logic             ch_sel, wr_ctrl, wr_pre, wr_cmp, wr_cnt;
    logic             tick, match, flag_clr;

    assign ch_sel  = we && (a_ch == CH_W'(i));
    assign wr_ctrl = ch_sel && (a_reg == 3'd0);
    assign wr_pre  = ch_sel && (a_reg == 3'd1);
    assign wr_cmp  = ch_sel && (a_reg == 3'd2);
    assign wr_cnt  = ch_sel && (a_reg == 3'd3);

    // >= rather than == so that shrinking PRESCALE below pc ticks on the next cycle
    assign tick     = en && (pc >= prescale);
    assign match    = tick && (count == compare);
    assign flag_clr = (wr_ctrl && wdata[3]) || (status_wr && wdata[i]);

    always_ff @(posedge clock) begin
      if (reset) begin
        en       <= 1'b0;
        periodic <= 1'b0;
        irqen    <= 1'b0;
        flag     <= 1'b0;
        prescale <= '0;
        pc       <= '0;
        compare  <= '0;
        count    <= '0;
      end else begin
        // a match always wins over a same-cycle software clear or enable
        if (match)         flag <= 1'b1;
        else if (flag_clr) flag <= 1'b0;

        if (match && !periodic) en <= 1'b0;
        else if (wr_ctrl)       en <= wdata[0];

        if (wr_ctrl) begin
          periodic <= wdata[1];
          irqen    <= wdata[2];
        end
        if (wr_pre) prescale <= wdata[PRE_W-1:0];
        if (wr_cmp) compare  <= wdata[CNT_W-1:0];

        if (wr_cnt) begin
          count <= wdata[CNT_W-1:0];
          pc    <= '0;
        end else begin
          if (en) pc <= tick ? '0 : pc + 1'b1;
          if (tick && !match)        count <= count + 1'b1;
          else if (match && periodic) count <= '0;
        end
      end
    end

`ifdef CAPTURE_EN
    logic cap_p0, cap_p1, cap_p2;

    always_ff @(posedge clock) begin
      if (reset) begin
        cap_p0  <= 1'b0;
        cap_p1  <= 1'b0;
        cap_p2  <= 1'b0;
        capture <= '0;
      end else begin
        // p0/p1: synchroniser, p2: previous value for edge detect
        cap_p0 <= capture_in[i];
        cap_p1 <= cap_p0;
        cap_p2 <= cap_p1;
        if (cap_p1 && !cap_p2) capture <= count;
      end
    end
`else
    assign capture = '0;
`endif

    assign en_v[i]    = en;
    assign per_v[i]   = periodic;
    assign irqen_v[i] = irqen;
    assign flag_v[i]  = flag;
    assign pre_v[i]   = prescale;
    assign cmp_v[i]   = compare;
    assign cnt_v[i]   = count;
    assign cap_v[i]   = capture;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (a_ch == CH_W'(i)) begin
        case (a_reg)
          3'd0:    rdata = {28'd0, flag_v[i], irqen_v[i], per_v[i], en_v[i]};
          3'd1:    rdata = 32'(pre_v[i]);
          3'd2:    rdata = 32'(cmp_v[i]);
          3'd3:    rdata = 32'(cnt_v[i]);
          3'd4:    rdata = 32'(cap_v[i]);
          default: rdata = '0;
        endcase
      end
    end
    if ((a_ch == CH_W'(NCH)) && (a_reg == 3'd0)) rdata = 32'(flag_v);
  end

  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(flag_v & irqen_v);
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed self-checking bench for mmio_timer_bank: reset, periodic/one-shot timing, wrap, write priority, W1C race, capture.
module tb_mmio_timer_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  capture_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mmio_timer_bank #(.NCH(4), .CNT_W(32), .PRE_W(16), .ADDR_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rdata),
    .capture_in (capture_in),
    .irq        (irq)
  );

  function automatic logic [7:0] ra(input int ch, input int r);
    ra = 8'((ch << 3) | (r & 7));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    addr  = ra(ch, r);
    wdata = d;
    we    = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    addr = ra(ch, r);
    #1;
    v = rdata;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    reset      = 1'b1;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    capture_in = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // reset mid-count on ch0
    wr(0, 1, 32'd5);
    wr(0, 2, 32'd100);
    wr(0, 3, 32'd7);
    wr(0, 0, 32'h5);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rd(0, 0, v); chk("rst_ctrl", v, 32'h0);
    rd(0, 1, v); chk("rst_pre", v, 32'h0);
    rd(0, 2, v); chk("rst_cmp", v, 32'h0);
    rd(0, 3, v); chk("rst_cnt", v, 32'h0);
    rd(0, 4, v); chk("rst_cap", v, 32'h0);
    rd(4, 0, v); chk("rst_status", v, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // periodic timing on ch1: tick every 4 cycles, match on 5th tick
    wr(1, 1, 32'd3);
    wr(1, 2, 32'd4);
    wr(1, 0, 32'h7);
    repeat (19) @(posedge clock);
    #1;
    rd(4, 0, v); chk("per_flag_pre", v, 32'h0);
    @(posedge clock);
    #1;
    rd(4, 0, v); chk("per_status", v, 32'h2);
    rd(1, 0, v); chk("per_ctrl", v, 32'hF);
    rd(1, 3, v); chk("per_cnt0", v, 32'h0);
    chk("per_irq_lag", 32'(irq), 32'h0);
    @(posedge clock);
    #1;
    chk("per_irq", 32'(irq), 32'h1);
    wr(4, 0, 32'h2);
    repeat (17) @(posedge clock);
    #1;
    rd(4, 0, v); chk("per2_pre", v, 32'h0);
    @(posedge clock);
    #1;
    rd(4, 0, v); chk("per2_flag", v, 32'h2);
    wr(1, 0, 32'h8);
    @(posedge clock);
    #1;
    chk("per_irq_off", 32'(irq), 32'h0);

    // one-shot on ch0
    wr(0, 1, 32'd0);
    wr(0, 2, 32'd2);
    wr(0, 0, 32'h1);
    @(posedge clock);
    @(posedge clock);
    #1;
    rd(0, 0, v); chk("os_ctrl_pre", v, 32'h1);
    rd(0, 3, v); chk("os_cnt_pre", v, 32'h2);
    @(posedge clock);
    #1;
    rd(0, 0, v); chk("os_ctrl", v, 32'h8);
    repeat (5) @(posedge clock);
    #1;
    rd(0, 3, v); chk("os_cnt_hold", v, 32'h2);
    wr(0, 0, 32'h8);
    rd(0, 0, v); chk("os_clr", v, 32'h0);

    // wrap and COUNT-write priority on ch2
    wr(2, 1, 32'd0);
    wr(2, 2, 32'd5);
    wr(2, 3, 32'hFFFF_FFFF);
    wr(2, 0, 32'h1);
    rd(2, 3, v); chk("wrap_pre", v, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    rd(2, 3, v); chk("wrap_cnt", v, 32'h0);
    wr(2, 3, 32'd9);
    rd(2, 3, v); chk("wr_cnt_tick", v, 32'd9);
    @(posedge clock);
    #1;
    rd(2, 3, v); chk("wr_cnt_next", v, 32'd10);
    wr(2, 0, 32'h0);

    // W1C race on ch3: STATUS clear lands on the match edge
    wr(3, 1, 32'd0);
    wr(3, 2, 32'd3);
    wr(3, 0, 32'h5);
    repeat (3) @(posedge clock);
    #1;
    wr(4, 0, 32'h8);
    rd(4, 0, v); chk("race_flag", v, 32'h8);
    chk("race_irq_lag", 32'(irq), 32'h0);
    wr(4, 0, 32'h8);
    rd(4, 0, v); chk("race_clr", v, 32'h0);
    chk("race_irq_on", 32'(irq), 32'h1);
    rd(3, 0, v); chk("race_ctrl", v, 32'h4);
    @(posedge clock);
    #1;
    chk("race_irq_off", 32'(irq), 32'h0);

    // reserved and unmapped addresses
    wr(0, 5, 32'hDEAD_BEEF);
    rd(0, 5, v); chk("rsvd", v, 32'h0);
    wr(5, 0, 32'h1234_5678);
    rd(5, 0, v); chk("unmapped", v, 32'h0);
    rd(4, 1, v); chk("status_rsvd", v, 32'h0);

    // capture on ch0
    wr(0, 2, 32'd1000);
    wr(0, 3, 32'd0);
    wr(0, 0, 32'h1);
    repeat (10) @(posedge clock);
    #1;
    rd(0, 3, v); chk("cap_cnt10", v, 32'd10);
    capture_in[0] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rd(0, 4, v);
`ifdef CAPTURE_EN
    chk("capture", v, 32'd12);
`else
    chk("capture", v, 32'd0);
`endif
    capture_in[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
